// File: rtl/sample_iterator.sv
`default_nettype none
// ============================================================================
//  Module   : sample_iterator
//  Purpose  : Raster stage ahead of the sample test. Accepts one triangle
//             with its sample-aligned bounding box and walks every sample
//             location of the box in raster order (x fastest, then y), one
//             sample per clock.
//  Ports    : clk, rst (async, active-low)
//             tri_R14S / color_R14U / box_R14S / validTri_R14H : triangle in
//             subSample_RnnnnU : one-hot sample rate (1000=1x ... 0001=64x)
//             halt_RnnnnL      : low while iterating, upstream must hold
//             tri_R16S / color_R16U : held triangle and colour
//             sample_R16S / validSamp_R16H : current sample and its valid
//  Option   : SAMPLE_ITERATOR_PERF_CNT_EN adds perfTri_RnnnnU and
//             perfSamp_RnnnnU saturating 32-bit event counters.
//  Revision : 1.0  initial release
// ============================================================================
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R14U  [COLORS],
    input  logic signed [SIGFIG-1:0] box_R14S    [2][2],
    input  logic                     validTri_R14H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R16S    [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R16U  [COLORS],
    output logic signed [SIGFIG-1:0] sample_R16S [2],
    output logic                     validSamp_R16H
`ifdef SAMPLE_ITERATOR_PERF_CNT_EN
    ,
    output logic        [31:0]       perfTri_RnnnnU,
    output logic        [31:0]       perfSamp_RnnnnU
`endif
);

    localparam logic signed [SIGFIG-1:0] c_STEP_1X  = SIGFIG'(1) << RADIX;
    localparam logic signed [SIGFIG-1:0] c_STEP_4X  = SIGFIG'(1) << (RADIX - 1);
    localparam logic signed [SIGFIG-1:0] c_STEP_16X = SIGFIG'(1) << (RADIX - 2);
    localparam logic signed [SIGFIG-1:0] c_STEP_64X = SIGFIG'(1) << (RADIX - 3);

    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_TEST = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic signed [SIGFIG-1:0] r_tri   [VERTS][AXIS];
    logic        [SIGFIG-1:0] r_color [COLORS];
    logic signed [SIGFIG-1:0] r_box   [2][2];
    logic signed [SIGFIG-1:0] r_x;
    logic signed [SIGFIG-1:0] r_y;
    logic                     r_valid;

    logic signed [SIGFIG-1:0] w_step;
    logic signed [SIGFIG-1:0] w_x_nxt;
    logic signed [SIGFIG-1:0] w_y_nxt;
    logic                     w_valid_nxt;
    logic                     w_accept;
    logic                     w_row_end;
    logic                     w_col_end;

    // Step decode; anything that is not one-hot falls back to 1x.
    always_comb begin
        w_step = c_STEP_1X;
        case (subSample_RnnnnU)
            4'b1000: w_step = c_STEP_1X;
            4'b0100: w_step = c_STEP_4X;
            4'b0010: w_step = c_STEP_16X;
            4'b0001: w_step = c_STEP_64X;
            default: w_step = c_STEP_1X;
        endcase
    end

    // For legal boxes the position only ever reaches ur by equality. The
    // greater-than term makes an illegal (ur < ll) box terminate instead of
    // walking the whole coordinate space.
    assign w_row_end = (r_x == r_box[1][0]) || (r_x > r_box[1][0]);
    assign w_col_end = (r_y == r_box[1][1]) || (r_y > r_box[1][1]);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_valid_nxt = r_valid;
        w_accept    = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (validTri_R14H) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_TEST;
                    w_x_nxt     = box_R14S[0][0];
                    w_y_nxt     = box_R14S[0][1];
                    w_valid_nxt = 1'b1;
                end
            end
            S_TEST: begin
                if (w_row_end && w_col_end) begin
                    // Last sample shown this cycle; position holds.
                    w_state_nxt = S_WAIT;
                    w_valid_nxt = 1'b0;
                end else if (w_row_end) begin
                    w_x_nxt = r_box[0][0];
                    w_y_nxt = r_y + w_step;
                end else begin
                    w_x_nxt = r_x + w_step;
                end
            end
            default: begin
                w_state_nxt = S_WAIT;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < AXIS; a++) begin
                    r_tri[v][a] <= '0;
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                r_color[c] <= '0;
            end
            for (int p = 0; p < 2; p++) begin
                r_box[p][0] <= '0;
                r_box[p][1] <= '0;
            end
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tri   <= tri_R14S;
                r_color <= color_R14U;
                r_box   <= box_R14S;
            end
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign halt_RnnnnL    = (r_state == S_WAIT);
    assign tri_R16S       = r_tri;
    assign color_R16U     = r_color;
    assign sample_R16S[0] = r_x;
    assign sample_R16S[1] = r_y;
    assign validSamp_R16H = r_valid;

`ifdef SAMPLE_ITERATOR_PERF_CNT_EN
    logic [31:0] r_perf_tri;
    logic [31:0] r_perf_samp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_tri  <= '0;
            r_perf_samp <= '0;
        end else begin
            if (w_accept && (r_perf_tri != 32'hFFFF_FFFF)) begin
                r_perf_tri <= r_perf_tri + 32'd1;
            end
            if (r_valid && (r_perf_samp != 32'hFFFF_FFFF)) begin
                r_perf_samp <= r_perf_samp + 32'd1;
            end
        end
    end

    assign perfTri_RnnnnU  = r_perf_tri;
    assign perfSamp_RnnnnU = r_perf_samp;
`else
    // Performance counters not built.
`endif

    // Upstream never produces a box with ur below ll on either axis.
    property p_box_legal;
        @(posedge clk) disable iff (!rst)
        (r_state == S_WAIT && validTri_R14H) |->
            (box_R14S[1][0] >= box_R14S[0][0]) && (box_R14S[1][1] >= box_R14S[0][1]);
    endproperty
    a_box_legal: assert property (p_box_legal);

endmodule
`default_nettype wire

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Raster stage directly upstream of the sample test.
- Accepts one triangle per handshake, together with its sample-aligned bounding box, and walks every sample location in the box in raster order.
- Emits one sample per cycle with the held triangle and color, ready for the R16 sample test.
- Stalls the bounding-box stage through an active-low halt while a triangle is being iterated.

Parameters:
- SIGFIG, 24, bits in color and position
- RADIX, 10, fraction bits in position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- tri_R14S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle from bounding-box stage
- color_R14U  in  unsigned [SIGFIG-1:0] [COLORS]  triangle color
- box_R14S  in  signed [SIGFIG-1:0] [2][2]  [0]=lower-left, [1]=upper-right; [*][0]=x, [*][1]=y; sample-aligned
- validTri_R14H  in  1  tri/box valid
- subSample_RnnnnU  in  4  one-hot sample rate: 1000=1x, 0100=4x, 0010=16x, 0001=64x
- halt_RnnnnL  out  1  low = upstream must hold its inputs
- tri_R16S  out  signed [SIGFIG-1:0] [VERTS][AXIS]  held triangle
- color_R16U  out  unsigned [SIGFIG-1:0] [COLORS]  held color
- sample_R16S  out  signed [SIGFIG-1:0] [2]  current sample (x,y)
- validSamp_R16H  out  1  sample_R16S is a real sample

Behaviour:
- Reset (rst low, asynchronous): state WAIT; tri_R16S, color_R16U, sample_R16S all 0; validSamp_R16H=0; halt_RnnnnL=1.
- Step size, decoded combinationally from subSample_RnnnnU: 1000→1<<RADIX, 0100→1<<(RADIX-1), 0010→1<<(RADIX-2), 0001→1<<(RADIX-3).
  - subSample_RnnnnU is static during iteration.
  - A non-one-hot value is treated as 1000.
- halt_RnnnnL = (state==WAIT), combinational from state only.
- WAIT state:
  - Transfer occurs when validTri_R14H=1.
  - On that edge: latch tri, color and box; set sample_R16S to box lower-left; go to TEST.
  - validSamp_R16H is registered and rises the cycle after acceptance (latency 1 clk from transfer to first sample).
- TEST state: one sample per cycle. At each edge:
  - If x==ur.x and y==ur.y: go to WAIT, validSamp_R16H←0, sample_R16S holds.
  - Else if x==ur.x: x←ll.x, y←y+step.
  - Else: x←x+step.
- Order: x fastest, then y, both increasing. Comparisons are full-width signed equality.
- Sample count per triangle = ((ur.x-ll.x)/step+1)*((ur.y-ll.y)/step+1).
- Degenerate box (ll==ur): exactly one sample, then WAIT.
- Back-to-back triangles: one bubble cycle between the last sample of triangle N and the first of N+1 (WAIT lasts one cycle while validTri_R14H stays high).
- validTri_R14H during TEST is ignored; the upstream stage must hold because halt_RnnnnL=0.
- No output backpressure: sample test is a fixed pipeline.
- Reset mid-TEST: immediate abort; outputs return to reset values; the partial triangle is dropped.
- Box with ur<ll on either axis is illegal; upstream never produces it. Behaviour is undefined, but the block must not lock up: an assertion fires.
- Add+compare on SIGFIG-bit signed; no overflow within the screen range.

Optional Feature:
- Macro: SAMPLE_ITERATOR_PERF_CNT_EN.
- Defined: adds outputs perfTri_RnnnnU [31:0] and perfSamp_RnnnnU [31:0].
  - perfTri_RnnnnU increments on each triangle acceptance.
  - perfSamp_RnnnnU increments each cycle validSamp_R16H=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- 1x rate, box ll=(0,0), ur=(2048,1024), validTri pulse → validSamp high 6 consecutive cycles starting 1 clk after accept, samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024); halt_RnnnnL low for those 6 cycles, then high.
- 4x rate, box ll=(512,512), ur=(1024,1024) → 4 samples (512,512),(1024,512),(512,1024),(1024,1024).
- Degenerate box ll=ur=(3072,2048) → exactly 1 sample (3072,2048), then halt_RnnnnL=1.
- Two triangles presented back-to-back with validTri held high (each 2x1 samples at 1x) → 2 samples, 1 bubble cycle, 2 samples; tri_R16S/color_R16U switch exactly at the first sample of the second triangle.
- rst asserted low on the 3rd sample of a 16-sample box → outputs 0, validSamp 0, halt_RnnnnL 1 without waiting for a clock edge; after release, a new triangle iterates from its own ll.
- With SAMPLE_ITERATOR_PERF_CNT_EN: run the first scenario twice → perfTri=2, perfSamp=12.
